// File: rtl/fod_spi_if.sv
// fod_spi_if: SPI pin bundle between the off-chip controller (master) and the FOD slave.
interface fod_spi_if;
  logic sck;
  logic scs_n;
  logic mosi;
  logic miso;
  modport master (output sck, scs_n, mosi, input miso);
  modport slave (input sck, scs_n, mosi, output miso);
endinterface

// File: rtl/fod_spi_slave.sv
// fod_spi_slave: oversampled SPI slave and FOD control register file; FOD_SPI_READBACK_EN enables the MISO read path.
`ifndef WI
`define WI 7
`endif
`ifndef WF
`define WF 16
`endif
module fod_spi_slave (
  input  logic                  clk,
  input  logic                  rst,
  fod_spi_if.slave              spi,
  output logic                  narst,
  output logic [`WI+`WF-1:0]    fcw_fod,
  output logic                  pcali_en,
  output logic                  freq_c_en,
  output logic                  freq_c_mode,
  output logic                  rt_en,
  output logic                  dtccali_en,
  output logic                  ofstcali_en,
  output logic                  fcw_dn_en,
  output logic                  sys_en,
  output logic                  dsm_sync_nrst_en,
  output logic                  nco_sync_nrst_en,
  output logic                  freq_hop,
  output logic [4:0]            freq_c_ks,
  output logic [4:0]            pcali_ks,
  output logic [4:0]            kb,
  output logic [4:0]            kc,
  output logic [4:0]            kd,
  output logic [2:0]            pcali_freqdown,
  output logic [1:0]            pseg,
  output logic [1:0]            caliorder,
  output logic [1:0]            fcw_dn_weight,
  output logic [9:0]            phase_ctrl,
  output logic [9:0]            kdtcb_init,
  output logic [9:0]            kdtcc_init,
  output logic [9:0]            kdtcd_init
);
  logic [2:0]  sck_s, cs_s;
  logic [1:0]  mosi_s;
  logic [4:0]  cnt;
  logic [14:0] sr;
  logic [15:0] din;
  logic [6:0]  addr_q;
  logic        rw_q, sck_rise, cs_fall, shift_en, wr;
  logic [14:0] ctrl0, cali, kgain;
  logic [15:0] fcw_sh;
  // Sync chains reset low so a chip select still held low after reset is not seen as a fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_s  <= '0;
      cs_s   <= '0;
      mosi_s <= '0;
      narst  <= 1'b0;
    end else begin
      sck_s  <= {sck_s[1:0], spi.sck};
      cs_s   <= {cs_s[1:0], spi.scs_n};
      mosi_s <= {mosi_s[0], spi.mosi};
      narst  <= 1'b1;
    end
  end
  assign sck_rise = sck_s[1] & ~sck_s[2];
  assign cs_fall  = ~cs_s[1] & cs_s[2];
  assign shift_en = sck_rise & ~cs_s[2] & (cnt < 5'd24);
  assign din      = {sr, mosi_s[1]};
  assign wr       = shift_en & (cnt == 5'd23) & rw_q;
  // A counter of 24 means "frame done or not armed"; only a real select fall re-arms it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 5'd24;
      sr     <= '0;
      addr_q <= '0;
      rw_q   <= 1'b0;
    end else if (cs_fall) begin
      cnt <= '0;
      sr  <= '0;
    end else if (shift_en) begin
      cnt <= cnt + 5'd1;
      sr  <= din[14:0];
      if (cnt == 5'd7) begin
        addr_q <= din[6:0];
        rw_q   <= din[7];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl0      <= 15'h7496;
      fcw_sh     <= 16'h4000;
      fcw_fod    <= 23'h044000;
      cali       <= 15'h6100;
      kgain      <= 15'h6FA0;
      phase_ctrl <= '0;
      kdtcb_init <= 10'd351;
      kdtcc_init <= 10'd195;
      kdtcd_init <= '0;
    end else if (wr) begin
      case (addr_q)
        7'h00: ctrl0 <= din[14:0];
        7'h01: fcw_sh <= din;
        7'h02: fcw_fod <= {din[6:0], fcw_sh};
        7'h03: cali <= din[14:0];
        7'h04: kgain <= din[14:0];
        7'h05: phase_ctrl <= din[9:0];
        7'h06: kdtcb_init <= din[9:0];
        7'h07: kdtcc_init <= din[9:0];
        7'h08: kdtcd_init <= din[9:0];
        default: ;
      endcase
    end
  end
  assign {pseg, fcw_dn_weight, fcw_dn_en, ofstcali_en, dtccali_en, rt_en, freq_c_mode,
          freq_c_en, pcali_en, freq_hop, nco_sync_nrst_en, dsm_sync_nrst_en, sys_en} = ctrl0;
  assign {caliorder, pcali_freqdown, pcali_ks, freq_c_ks} = cali;
  assign {kd, kc, kb} = kgain;
`ifdef FOD_SPI_READBACK_EN
  logic        sck_fall, miso_q;
  logic [15:0] rd, miso_sr;
  assign sck_fall = ~sck_s[1] & sck_s[2];
  always_comb begin
    rd = '0;
    case (din[6:0])
      7'h00: rd = {1'b0, ctrl0};
      7'h01: rd = fcw_sh;
      7'h02: rd = {9'b0, fcw_fod[22:16]};
      7'h03: rd = {1'b0, cali};
      7'h04: rd = {1'b0, kgain};
      7'h05: rd = {6'b0, phase_ctrl};
      7'h06: rd = {6'b0, kdtcb_init};
      7'h07: rd = {6'b0, kdtcc_init};
      7'h08: rd = {6'b0, kdtcd_init};
      default: ;
    endcase
  end
  // Read data is latched with the address so the first fall already presents bit 15.
  always_ff @(posedge clk) begin
    if (rst) begin
      miso_q  <= 1'b0;
      miso_sr <= '0;
    end else if (cs_s[1]) begin
      miso_q <= 1'b0;
    end else if (shift_en && cnt == 5'd7 && !din[7]) begin
      miso_sr <= rd;
    end else if (sck_fall && !rw_q && cnt >= 5'd8 && cnt <= 5'd23) begin
      {miso_q, miso_sr} <= {miso_sr, 1'b0};
    end
  end
  assign spi.miso = miso_q;
`else
  assign spi.miso = 1'b0;
`endif
endmodule

// File: doc/fod_spi_slave.md
# fod_spi_slave

SPI slave and control register file for the FOD. It receives 24-bit serial frames from the off-chip controller and holds every FOD control field in registers. It drives those fields as static outputs straight into the FOD digital controller, so the FOD's control inputs are programmable at run time rather than fixed at elaboration. All logic runs on the FOD digital clock. SPI pins are oversampled and are not used as clocks.

## Interface
- Parameters: none. `WI`/`WF` come from the global defines; FCW width is `WI+WF` = 23.
- CLK  in  1  FOD digital clock; all state on rising edge
- RST  in  1  synchronous, active-high reset
- SCK  in  1  SPI clock, mode 0, asynchronous to CLK
- SCS_N  in  1  SPI chip select, active low
- MOSI  in  1  serial data in, MSB first
- MISO  out  1  serial read data
- NARST  out  1  FOD reset, active low; registered ~RST
- FCW_FOD  out  23  frequency control word
- PCALI_EN, FREQ_C_EN, FREQ_C_MODE, RT_EN, DTCCALI_EN, OFSTCALI_EN, FCW_DN_EN, SYS_EN, DSM_SYNC_NRST_EN, NCO_SYNC_NRST_EN, FREQ_HOP  out  1 each  control bits
- FREQ_C_KS, PCALI_KS, KB, KC, KD  out  5 each  gains; KB/KC/KD are two's complement
- PCALI_FREQDOWN  out  3
- PSEG, CALIORDER, FCW_DN_WEIGHT  out  2 each
- PHASE_CTRL, KDTCB_INIT, KDTCC_INIT, KDTCD_INIT  out  10 each

## Operation
- **Input sync:** SCK, SCS_N and MOSI each pass through a 2-FF synchronizer. SCK rise and fall are detected from the synchronized value against its previous value.
- **Frame format:** SCS_N falling clears the bit counter (5 bits) and the shift register. On each SCK rise with SCS_N low, MOSI shifts in.
  - bit23 = RW (1 = write)
  - [22:16] = address
  - [15:0] = data
- **Address capture:** after the 8th bit, the address is latched. On a read, the addressed register is loaded into the MISO shift register.
- **Write commit:** on the 24th rise, a write updates the addressed register, in the same CLK cycle as the edge detect.
- **Extra bits:** rises after the 24th are ignored until SCS_N goes high.
- **Aborted frame:** SCS_N rising before 24 bits discards the frame; no register changes.
- **Register map:**
  - 0x00 CTRL0, reset 0x7496:
    - [0] SYS_EN, [1] DSM_SYNC_NRST_EN, [2] NCO_SYNC_NRST_EN, [3] FREQ_HOP
    - [4] PCALI_EN, [5] FREQ_C_EN, [6] FREQ_C_MODE, [7] RT_EN
    - [8] DTCCALI_EN, [9] OFSTCALI_EN, [10] FCW_DN_EN
    - [12:11] FCW_DN_WEIGHT, [14:13] PSEG, [15] reserved (reads 0)
  - 0x01 FCW_LO [15:0], reset 0x4000.
  - 0x02 FCW_HI [6:0], reset 0x04. FCW reset value = 4.25·2^16 = 0x044000.
  - 0x03 CALI, reset 0x6100: [4:0] FREQ_C_KS, [9:5] PCALI_KS, [12:10] PCALI_FREQDOWN, [14:13] CALIORDER.
  - 0x04 KGAIN, reset 0x6FA0: [4:0] KB=0, [9:5] KC=-3, [14:10] KD=-5.
  - 0x05 PHASE_CTRL [9:0], reset 0.
  - 0x06 / 0x07 / 0x08: KDTCB_INIT / KDTCC_INIT / KDTCD_INIT [9:0], resets 351 / 195 / 0.
- **FCW atomicity:**
  - A FCW_LO write goes to a shadow register only.
  - A FCW_HI write updates FCW_FOD[22:16] and copies the shadow into FCW_FOD[15:0] in the same cycle.
  - Reading FCW_LO returns the shadow.
- **Width rules:** unused data bits are ignored on write and read as 0.
- **Unmapped addresses:** 0x09-0x7F writes are ignored; reads return 0.
- **Reset:** all registers, the shadow, counters and MISO reset in the same cycle. Reset mid-frame aborts the frame. After RST falls, the next valid frame requires a fresh SCS_N fall.

## Timing
- CLK must be ≥ 8× SCK frequency, with SCK high and low each ≥ 3 CLK periods.
- An SCK edge first sampled at CLK edge n is detected at n+2. Register outputs change at n+3.
- MISO is updated on the synchronized SCK fall, so the master samples it on the next rise. Bit 15 of the read data is valid before data rise 1.
- While SCS_N is high, MISO = 0.
- NARST is 0 during RST and 1 one cycle after RST deasserts.
- Simultaneous SCS_N rise and 24th SCK rise in the same synchronized cycle: the frame is treated as complete and the write commits.

## Configuration
- Macro: `FOD_SPI_READBACK_EN`.
- Defined: the read path is active (MISO shift register and read mux).
- Undefined: MISO is tied to 0. RW=0 frames are consumed with no effect, and the read mux is not built.

## Test plan
- Reset check: assert RST for 2 cycles. Require FCW_FOD=0x044000, CTRL0 fields per 0x7496, KC=5'b11101, KD=5'b11011, KDTCB_INIT=351, NARST 0→1.
- Atomic FCW update: write 0x01←0x8000, then check FCW_FOD still 0x044000. Write 0x02←0x05, then require FCW_FOD=0x058000, stable through the 3rd cycle after the edge.
- Readback: with `FOD_SPI_READBACK_EN`, write 0x04←0x1234 then read 0x04. Require MISO = 0x1234 & 0x7FFF = 0x1234 and KB=0x14.
- Abort and unmapped: raise SCS_N after 20 bits of 0x05←0x03FF, then require PHASE_CTRL unchanged. Write 0x7F←0xFFFF and read it back, then require no change and read data 0.
- Mid-frame reset and extra bits: assert RST at bit 12 of a write, then require reset values and that the next full frame writes correctly. A 30-bit frame must commit only its first 24 bits.
